// File: rtl/butterfly_pipe.sv
// butterfly_pipe: 3-stage radix-2 DIT/DIF butterfly with rounding, optional halving and saturation
// Ports: clk/rst (sync, active-high); in_valid/in_ready input handshake carrying in1, in2, twiddle ro,
//        mode (0=DIT,1=DIF), scale (1=halve); out_valid/out_ready output handshake carrying out1, out2,
//        out_sat (this beat clipped); ovf_sticky latches any transferred clipped beat until ovf_clear.
module butterfly_pipe #(
  parameter int DATA_WIDTH = 8,
  parameter int EXPAND = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in1_real,
  input  logic signed [DATA_WIDTH-1:0] in1_imag,
  input  logic signed [DATA_WIDTH-1:0] in2_real,
  input  logic signed [DATA_WIDTH-1:0] in2_imag,
  input  logic signed [EXPAND+1:0]     ro_real,
  input  logic signed [EXPAND+1:0]     ro_imag,
  input  logic                         mode,
  input  logic                         scale,
  output logic signed [DATA_WIDTH:0]   out1_real,
  output logic signed [DATA_WIDTH:0]   out1_imag,
  output logic signed [DATA_WIDTH:0]   out2_real,
  output logic signed [DATA_WIDTH:0]   out2_imag,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_sat,
  output logic                         ovf_sticky,
  input  logic                         ovf_clear
);
  localparam int DW = DATA_WIDTH;
  localparam int TW = EXPAND + 2;
  localparam int PW = DW + TW + 2;
  localparam int SW = PW + 1;
  localparam logic signed [PW-1:0] HALF = PW'(1) << (EXPAND - 1);
  localparam logic signed [SW-1:0] ONE = SW'(1);
  localparam logic signed [SW-1:0] HI = (SW'(1) << DW) - ONE;
  localparam logic signed [SW-1:0] LO = ~HI;
  logic adv;
  logic v1, v2, v3, m1, m2, sc1, sc2, sat, ovf;
  logic signed [DW-1:0] a1r, a1i, b1r, b1i;
  logic signed [TW-1:0] w1r, w1i;
  logic signed [DW:0] xr, xi, yr, yi, y2r, y2i;
  logic signed [PW-1:0] pr, pi, p2r, p2i;
  logic signed [SW-1:0] s [4];
  logic signed [SW-1:0] t [4];
  logic signed [DW:0] c [4];
  logic signed [DW:0] o [4];
  logic [3:0] h;
  assign adv = !v3 || out_ready;
  assign in_ready = adv || rst;
  // multiplier operand x and pass-through y: DIT multiplies in2, DIF multiplies in1-in2
  always_comb begin
    xr = m1 ? (DW+1)'(a1r) - (DW+1)'(b1r) : (DW+1)'(b1r);
    xi = m1 ? (DW+1)'(a1i) - (DW+1)'(b1i) : (DW+1)'(b1i);
    yr = m1 ? (DW+1)'(a1r) + (DW+1)'(b1r) : (DW+1)'(a1r);
    yi = m1 ? (DW+1)'(a1i) + (DW+1)'(b1i) : (DW+1)'(a1i);
    pr = (PW'(xr) * PW'(w1r) - PW'(xi) * PW'(w1i) + HALF) >>> EXPAND;
    pi = (PW'(xr) * PW'(w1i) + PW'(xi) * PW'(w1r) + HALF) >>> EXPAND;
  end
  // DIT: y +/- p; DIF: sum passes through, product is the second result
  always_comb begin
    s[0] = m2 ? SW'(y2r) : SW'(y2r) + SW'(p2r);
    s[1] = m2 ? SW'(y2i) : SW'(y2i) + SW'(p2i);
    s[2] = m2 ? SW'(p2r) : SW'(y2r) - SW'(p2r);
    s[3] = m2 ? SW'(p2i) : SW'(y2i) - SW'(p2i);
    for (int k = 0; k < 4; k++) begin
      t[k] = sc2 ? (s[k] + ONE) >>> 1 : s[k];
      h[k] = t[k] > HI || t[k] < LO;
      c[k] = t[k] > HI ? HI[DW:0] : t[k] < LO ? LO[DW:0] : t[k][DW:0];
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      {v1, v2, v3, m1, m2, sc1, sc2, sat} <= '0;
      {a1r, a1i, b1r, b1i, w1r, w1i} <= '0;
      {y2r, y2i, p2r, p2i} <= '0;
      o <= '{default: '0};
    end else if (adv) begin
      v1 <= in_valid;
      m1 <= mode;
      sc1 <= scale;
      a1r <= in1_real;
      a1i <= in1_imag;
      b1r <= in2_real;
      b1i <= in2_imag;
      w1r <= ro_real;
      w1i <= ro_imag;
      v2 <= v1;
      m2 <= m1;
      sc2 <= sc1;
      y2r <= yr;
      y2i <= yi;
      p2r <= pr;
      p2i <= pi;
      v3 <= v2;
      o <= c;
      sat <= |h;
    end
  // a clipped beat transferring in the same cycle as ovf_clear keeps the flag set
  always_ff @(posedge clk)
    if (rst) ovf <= 1'b0;
    else if (v3 && out_ready && sat) ovf <= 1'b1;
    else if (ovf_clear) ovf <= 1'b0;
  assign out1_real = o[0];
  assign out1_imag = o[1];
  assign out2_real = o[2];
  assign out2_imag = o[3];
  assign out_valid = v3;
  assign out_sat = sat;
  assign ovf_sticky = ovf;
endmodule

// File: tb/tb_butterfly_pipe.sv
// tb_butterfly_pipe: scoreboard bench for butterfly_pipe with directed and random beats
module tb_butterfly_pipe;
  localparam int DW = 8;
  localparam int EX = 6;
  logic clk = 0, rst = 1;
  logic in_valid = 0, mode = 0, scale = 0, out_ready = 1, ovf_clear = 0;
  logic in_ready, out_valid, out_sat, ovf_sticky;
  logic signed [DW-1:0] in1_real = 0, in1_imag = 0, in2_real = 0, in2_imag = 0;
  logic signed [EX+1:0] ro_real = 0, ro_imag = 0;
  logic signed [DW:0] out1_real, out1_imag, out2_real, out2_imag;
  typedef struct packed {int o1r; int o1i; int o2r; int o2i; logic sat;} exp_t;
  exp_t q[$];
  exp_t e;
  int errors = 0, checks = 0;
  logic exp_ovf = 0;
  always #5 clk = ~clk;
  butterfly_pipe #(.DATA_WIDTH(DW), .EXPAND(EX)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in1_real(in1_real), .in1_imag(in1_imag), .in2_real(in2_real), .in2_imag(in2_imag),
    .ro_real(ro_real), .ro_imag(ro_imag), .mode(mode), .scale(scale),
    .out1_real(out1_real), .out1_imag(out1_imag), .out2_real(out2_real), .out2_imag(out2_imag),
    .out_valid(out_valid), .out_ready(out_ready), .out_sat(out_sat),
    .ovf_sticky(ovf_sticky), .ovf_clear(ovf_clear)
  );
  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask
  function automatic int rnd(input int x);
    return (x + (1 << (EX - 1))) >>> EX;
  endfunction
  // plain complex arithmetic: DIT p=in2*W, out=in1+/-p; DIF out1=in1+in2, out2=(in1-in2)*W
  function automatic exp_t model(input int ar, ai, br, bi, wr, wi, input logic m, input logic s);
    int r[4];
    int pr, pi;
    exp_t x;
    x.sat = 0;
    if (m) begin
      r[0] = ar + br;
      r[1] = ai + bi;
      r[2] = rnd((ar - br) * wr - (ai - bi) * wi);
      r[3] = rnd((ar - br) * wi + (ai - bi) * wr);
    end else begin
      pr = rnd(br * wr - bi * wi);
      pi = rnd(br * wi + bi * wr);
      r[0] = ar + pr;
      r[1] = ai + pi;
      r[2] = ar - pr;
      r[3] = ai - pi;
    end
    for (int k = 0; k < 4; k++) begin
      if (s) r[k] = (r[k] + 1) >>> 1;
      if (r[k] > (1 << DW) - 1) begin r[k] = (1 << DW) - 1; x.sat = 1; end
      else if (r[k] < -(1 << DW)) begin r[k] = -(1 << DW); x.sat = 1; end
    end
    x.o1r = r[0]; x.o1i = r[1]; x.o2r = r[2]; x.o2i = r[3];
    return x;
  endfunction
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      exp_ovf = 0;
    end else begin
      chk("ovf_sticky", ovf_sticky, exp_ovf);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got out1=(%0d,%0d) want none", out1_real, out1_imag);
        end else begin
          e = q.pop_front();
          chk("out1_real", out1_real, e.o1r);
          chk("out1_imag", out1_imag, e.o1i);
          chk("out2_real", out2_real, e.o2r);
          chk("out2_imag", out2_imag, e.o2i);
          chk("out_sat", out_sat, e.sat);
          if (e.sat) exp_ovf = 1;
          else if (ovf_clear) exp_ovf = 0;
        end
      end else if (ovf_clear) exp_ovf = 0;
      if (in_valid && in_ready)
        q.push_back(model(in1_real, in1_imag, in2_real, in2_imag, ro_real, ro_imag, mode, scale));
    end
  end
  task automatic rand_beat();
    in1_real = DW'($urandom); in1_imag = DW'($urandom);
    in2_real = DW'($urandom); in2_imag = DW'($urandom);
    ro_real = (EX+2)'($urandom); ro_imag = (EX+2)'($urandom);
    mode = 1'($urandom); scale = 1'($urandom);
  endtask
  // single beat into an empty pipeline; checks 3-cycle latency and the constant results
  task automatic direct(input string name, input int a_r, a_i, b_r, b_i, w_r, w_i, input logic m, s,
                        input int e1r, e1i, e2r, e2i, input logic esat);
    in1_real = DW'(a_r); in1_imag = DW'(a_i); in2_real = DW'(b_r); in2_imag = DW'(b_i);
    ro_real = (EX+2)'(w_r); ro_imag = (EX+2)'(w_i); mode = m; scale = s;
    chk({name, "_in_ready"}, in_ready, 1);
    in_valid = 1;
    @(posedge clk); #1 in_valid = 0;
    @(posedge clk); #1 chk({name, "_early"}, out_valid, 0);
    @(posedge clk); #1 chk({name, "_valid"}, out_valid, 1);
    chk({name, "_o1r"}, out1_real, e1r);
    chk({name, "_o1i"}, out1_imag, e1i);
    chk({name, "_o2r"}, out2_real, e2r);
    chk({name, "_o2i"}, out2_imag, e2i);
    chk({name, "_sat"}, out_sat, esat);
    repeat (2) @(posedge clk);
    #1;
  endtask
  int h1r, h2i, hsat;
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_sat", out_sat, 0);
    chk("rst_ovf", ovf_sticky, 0);
    chk("rst_out1_real", out1_real, 0);
    chk("rst_out2_imag", out2_imag, 0);
    rst = 0;
    direct("dit_w1", 10, 20, 3, -4, 64, 0, 0, 0, 13, 16, 7, 24, 0);
    direct("dit_w1_scale", 10, 20, 3, -4, 64, 0, 0, 1, 7, 8, 4, 12, 0);
    direct("dit_wj", 10, 20, 3, -4, 0, -64, 0, 0, 6, 17, 14, 23, 0);
    direct("dif_wj", 10, 20, 3, -4, 0, -64, 1, 0, 13, 16, 24, -7, 0);
    direct("dit_sat", 127, 127, 127, 127, 127, 127, 0, 0, 127, 255, 127, -256, 1);
    chk("ovf_set", ovf_sticky, 1);
    repeat (2) @(posedge clk);
    #1 chk("ovf_hold", ovf_sticky, 1);
    ovf_clear = 1;
    @(posedge clk); #1 ovf_clear = 0;
    chk("ovf_cleared", ovf_sticky, 0);
    out_ready = 0;
    in_valid = 1;
    for (int k = 0; k < 3; k++) begin
      rand_beat();
      @(posedge clk); #1;
    end
    rand_beat();
    chk("stall_valid", out_valid, 1);
    h1r = out1_real; h2i = out2_imag; hsat = out_sat;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_hold_o1r", out1_real, h1r);
      chk("stall_hold_o2i", out2_imag, h2i);
      chk("stall_hold_sat", out_sat, hsat);
    end
    out_ready = 1;
    @(posedge clk); #1 in_valid = 0;
    repeat (6) @(posedge clk);
    #1 chk("stall_drain", q.size(), 0);
    in_valid = 1;
    rand_beat();
    @(posedge clk); #1 rand_beat();
    @(posedge clk); #1 in_valid = 0;
    rst = 1;
    @(posedge clk); #1 chk("flush_out_valid", out_valid, 0);
    rst = 0;
    chk("post_rst_in_ready", in_ready, 1);
    in_valid = 1;
    rand_beat();
    @(posedge clk); #1 in_valid = 0;
    repeat (6) @(posedge clk);
    #1 chk("post_rst_drain", q.size(), 0);
    for (int k = 0; k < 800; k++) begin
      in_valid = 1'($urandom);
      rand_beat();
      if ($urandom_range(0, 3) == 0) begin
        in1_real = 8'sd127; in2_real = 8'sd127; ro_real = 8'sd127; ro_imag = 8'sd127;
      end
      out_ready = $urandom_range(0, 3) != 0;
      ovf_clear = $urandom_range(0, 7) == 0;
      @(posedge clk); #1;
    end
    in_valid = 0; out_ready = 1; ovf_clear = 0;
    repeat (8) @(posedge clk);
    #1 chk("final_drain", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
